// File: rtl/dcache_array_pkg.sv
// Shared types and helpers for the dcache banked register array.
// lane_merge is used by both the bank write path and the forwarding mux.
package dcache_array_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Upper bound on entry width handled by lane_merge; callers size-cast in and out.
    localparam int MAX_WIDTH = 1024;

    function automatic logic [MAX_WIDTH-1:0] lane_merge(
        input logic [MAX_WIDTH-1:0] old_val,
        input logic [MAX_WIDTH-1:0] new_val,
        input logic [MAX_WIDTH-1:0] mask,
        input int                   gran
    );
        logic [MAX_WIDTH-1:0] merged;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            merged[i] = mask[i/gran] ? new_val[i] : old_val[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_way_bank.sv
// One way of the dcache array: NUM_SETS entries with lane-masked writes
// and a write-to-read forwarding mux on the read side.
module dcache_way_bank
    import dcache_array_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 32,
    parameter int GRAN    = 8,
    localparam int LANES    = WIDTH / GRAN,
    localparam int NUM_SETS = 2 ** S_INDEX
) (
    input  logic               clk,
    input  logic               we,
    input  logic [S_INDEX-1:0] windex,
    input  logic [LANES-1:0]   wmask,
    input  logic [WIDTH-1:0]   datain,
    input  logic [S_INDEX-1:0] rindex,
    output logic [WIDTH-1:0]   fwd
);

    logic [WIDTH-1:0] mem_q [NUM_SETS];
    logic [WIDTH-1:0] mem_d [NUM_SETS];
    logic [WIDTH-1:0] merged;

    assign merged = WIDTH'(lane_merge(MAX_WIDTH'(mem_q[windex]), MAX_WIDTH'(datain),
                                      MAX_WIDTH'(wmask), GRAN));

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[windex] = merged;
        end
    end

    // NOTE: storage has no reset; the top's clear sweep initialises every entry over NUM_SETS cycles.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // On a same-set write, merged already holds stored lanes for the unmasked bits.
    assign fwd = (we && (rindex == windex)) ? merged : mem_q[rindex];

endmodule

// File: rtl/dcache_banked_array.sv
// Multi-way dcache register array: WAYS banks, post-reset clear sweep,
// optional registered read port with hold, and write-to-read forwarding.
module dcache_banked_array
    import dcache_array_pkg::*;
#(
    parameter int               S_INDEX   = 3,
    parameter int               WIDTH     = 32,
    parameter int               WAYS      = 2,
    parameter int               GRAN      = 8,
    parameter int               REG_READ  = 1,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
    localparam int LANES    = WIDTH / GRAN,
    localparam int NUM_SETS = 2 ** S_INDEX
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  read,
    input  logic [S_INDEX-1:0]    rindex,
    output logic [WAYS*WIDTH-1:0] dataout,
    input  logic [WAYS-1:0]       load,
    input  logic [S_INDEX-1:0]    windex,
    input  logic [LANES-1:0]      wmask,
    input  logic [WIDTH-1:0]      datain
);

    state_e             state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            cnt_d = cnt_q + S_INDEX'(1);
            if (cnt_q == S_INDEX'(NUM_SETS - 1)) begin
                state_d = READY;
            end
        end
    end

    // NOTE: reset is synchronous, so it is folded into the next-state logic rather than the sensitivity list.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    logic clearing;
    logic active;

    assign busy     = rst || (state_q == CLEAR);
    assign clearing = !rst && (state_q == CLEAR);
    assign active   = !busy;

    // The sweep borrows each bank's write port with a full mask.
    logic [S_INDEX-1:0]    bank_windex;
    logic [LANES-1:0]      bank_wmask;
    logic [WIDTH-1:0]      bank_datain;
    logic [WAYS*WIDTH-1:0] fwd_all;

    assign bank_windex = clearing ? cnt_q : windex;
    assign bank_wmask  = clearing ? '1 : wmask;
    assign bank_datain = clearing ? CLEAR_VAL : datain;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic bank_we;
        assign bank_we = clearing || (active && load[w]);

        dcache_way_bank #(
            .S_INDEX(S_INDEX),
            .WIDTH  (WIDTH),
            .GRAN   (GRAN)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .windex(bank_windex),
            .wmask (bank_wmask),
            .datain(bank_datain),
            .rindex(rindex),
            .fwd   (fwd_all[w*WIDTH +: WIDTH])
        );
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [WAYS*WIDTH-1:0] dout_q, dout_d;

        // Without a read strobe the register holds, even if its set is rewritten.
        always_comb begin
            dout_d = dout_q;
            if (rst) begin
                dout_d = '0;
            end else if (active && read) begin
                dout_d = fwd_all;
            end
        end

        always_ff @(posedge clk) begin
            dout_q <= dout_d;
        end

        assign dataout = busy ? '0 : dout_q;
    end else begin : g_comb_read
        logic unused_read;
        assign unused_read = read;
        assign dataout     = busy ? '0 : fwd_all;
    end

endmodule

// File: tb/tb_dcache_banked_array.sv
// Scoreboard bench for dcache_banked_array: registered-read instance checked via an
// expectation queue, combinational-read instance checked directly in its cycle.
module tb_dcache_banked_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [2:0]  rindex;
    logic [1:0]  load;
    logic [2:0]  windex;
    logic [3:0]  wmask;
    logic [31:0] datain;
    logic        busy_r, busy_c;
    logic [63:0] dout_r, dout_c;

    logic peek;
    logic vld_pipe = 1'b0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dcache_banked_array #(.REG_READ(1)) dut_r (
        .clk(clk), .rst(rst), .busy(busy_r), .read(read), .rindex(rindex),
        .dataout(dout_r), .load(load), .windex(windex), .wmask(wmask), .datain(datain)
    );

    dcache_banked_array #(.REG_READ(0)) dut_c (
        .clk(clk), .rst(rst), .busy(busy_c), .read(read), .rindex(rindex),
        .dataout(dout_c), .load(load), .windex(windex), .wmask(wmask), .datain(datain)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A registered read (or a tb peek) in one cycle makes dataout observable in the next.
    always @(posedge clk) vld_pipe <= (read && !busy_r) || peek;

    always @(negedge clk) begin
        if (vld_pipe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", dout_r, 64'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, dout_r, e.val);
            end
        end
    end

    task automatic push(input string name, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        read = 1'b0; rindex = '0; load = '0; windex = '0; wmask = '0; datain = '0; peek = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] ld, input logic [2:0] idx, input logic [3:0] m,
                         input logic [31:0] d);
        load = ld; windex = idx; wmask = m; datain = d;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy_r) n++;
            else break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        idle();
        tick();
        check("busy_in_rst", {63'd0, busy_r}, 64'd1);
        check("dout_in_rst", dout_r, 64'd0);
        tick();
        rst = 1'b0;

        // Reset sweep length, then every set reads back as cleared.
        count_busy(n);
        check("sweep_len", 64'(n), 64'd8);
        check("busy_c_after_sweep", {63'd0, busy_c}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            idle(); read = 1'b1; rindex = 3'(i);
            push($sformatf("clr_set%0d", i), 64'h0);
            tick();
        end

        // Masked write: second write touches only lane 1.
        idle(); write(2'b01, 3'd3, 4'b1111, 32'hAABBCCDD); tick();
        write(2'b01, 3'd3, 4'b0010, 32'h00001100); tick();
        idle(); read = 1'b1; rindex = 3'd3;
        push("masked_write", 64'h00000000_AABB11DD); tick();

        // Forwarding: partial write to way1 set5 in the same cycle as the read.
        idle(); write(2'b10, 3'd5, 4'b1111, 32'hFFFFFFFF); tick();
        write(2'b10, 3'd5, 4'b0011, 32'h12345678); read = 1'b1; rindex = 3'd5;
        push("fwd_same_cycle", 64'hFFFF5678_00000000); tick();
        idle(); read = 1'b1; rindex = 3'd5;
        push("fwd_stored", 64'hFFFF5678_00000000); tick();

        // Read and write to different sets do not interact.
        idle(); write(2'b01, 3'd4, 4'b1111, 32'h55555555); read = 1'b1; rindex = 3'd3;
        push("diff_set_read", 64'h00000000_AABB11DD); tick();
        idle(); read = 1'b1; rindex = 3'd4;
        push("diff_set_written", 64'h00000000_55555555); tick();

        // load with an empty lane mask is a no-op.
        idle(); write(2'b11, 3'd3, 4'b0000, 32'hFFFFFFFF); read = 1'b1; rindex = 3'd3;
        push("mask0_fwd", 64'h00000000_AABB11DD); tick();
        idle(); read = 1'b1; rindex = 3'd3;
        push("mask0_stored", 64'h00000000_AABB11DD); tick();

        // Hold: dataout keeps the old set2 value across a write until re-read.
        idle(); write(2'b01, 3'd2, 4'b1111, 32'h0000CAFE); tick();
        idle(); read = 1'b1; rindex = 3'd2;
        push("hold_first", 64'h00000000_0000CAFE); tick();
        idle(); write(2'b01, 3'd2, 4'b1111, 32'hDEADBEEF); peek = 1'b1;
        push("hold_during_write", 64'h00000000_0000CAFE); tick();
        idle(); peek = 1'b1;
        push("hold_after_write", 64'h00000000_0000CAFE); tick();
        idle(); read = 1'b1; rindex = 3'd2;
        push("hold_reread", 64'h00000000_DEADBEEF); tick();
        idle(); tick();

        // Reset mid-sweep restarts the sweep; accesses during busy are ignored.
        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (4) tick();
        check("busy_mid_sweep", {63'd0, busy_r}, 64'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        write(2'b11, 3'd1, 4'b1111, 32'h11111111); read = 1'b1; rindex = 3'd1;
        #1;
        check("dout_r_busy", dout_r, 64'd0);
        check("dout_c_busy", dout_c, 64'd0);
        count_busy(n);
        check("restart_sweep_len", 64'(n), 64'd8);
        idle(); read = 1'b1; rindex = 3'd1;
        push("set1_after_sweep", 64'h0);
        #1;
        check("comb_set1_after_sweep", dout_c, 64'd0);
        tick();
        idle(); tick();

        // Combinational read port shows same-cycle write data.
        idle(); write(2'b01, 3'd6, 4'b1111, 32'h01020304); rindex = 3'd6;
        #1;
        check("comb_fwd", dout_c, 64'h00000000_01020304);
        tick();
        idle(); rindex = 3'd6;
        #1;
        check("comb_stored", dout_c, 64'h00000000_01020304);
        tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_banked_array.md
Name: dcache_banked_array

Overview:
- Parametrised multi-way metadata/data register array for the dcache: WAYS independent banks of 2**S_INDEX sets, WIDTH bits each.
- Adds byte-lane write masks, per-way write enables, an optional registered read port with hold, and write-to-read forwarding.
- Adds a sequential clear sweep after reset, so large arrays need no single-cycle reset.
- Serves tag, valid/dirty, LRU and small data arrays in the dcache datapath.

Parameters:
- S_INDEX, 3, index width; NUM_SETS = 2**S_INDEX.
- WIDTH, 32, bits per entry; must be a multiple of GRAN.
- WAYS, 2, number of banks (ways).
- GRAN, 8, bits per write-mask lane; LANES = WIDTH/GRAN.
- REG_READ, 1, 1 = registered read with hold, 0 = combinational read.
- CLEAR_VAL, '0, WIDTH-bit value written to every entry by the clear sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- busy  out  1  clear sweep in progress; all accesses are ignored while high.
- read  in  1  read strobe (used only when REG_READ=1).
- rindex  in  S_INDEX  read set index.
- dataout  out  WAYS*WIDTH  way w occupies bits [w*WIDTH +: WIDTH].
- load  in  WAYS  per-way write enable.
- windex  in  S_INDEX  write set index (shared by all ways).
- wmask  in  LANES  lane write mask; bit l covers bits [l*GRAN +: GRAN].
- datain  in  WIDTH  write data (shared by all ways).

Behaviour:
- FSM states: CLEAR, READY; clear counter cnt is S_INDEX bits wide.
- rst high: state <= CLEAR, cnt <= 0, busy = 1, registered dataout <= 0. No array writes occur while rst is high.
- CLEAR, rst low:
  - Each cycle writes CLEAR_VAL to set cnt in every way, then increments cnt.
  - After cnt == NUM_SETS-1 is written, the next state is READY.
  - busy stays high for exactly NUM_SETS cycles after rst falls.
- rst asserted mid-sweep: the sweep restarts from cnt = 0.
- While busy: load, wmask and read are ignored; dataout = 0 in both REG_READ modes.
- READY, write: for each way w with load[w] = 1 and each lane l with wmask[l] = 1, data[w][windex] lane l <= datain lane l. Unmasked lanes keep their value. load[w] with wmask = 0 is a no-op.
- Forwarded value fwd[w]:
  - Equals data[w][rindex], except when load[w] = 1 and rindex == windex.
  - In that case, masked lanes come from datain and unmasked lanes from stored data.
  - Forwarding is per way: ways not loaded show stored data.
- REG_READ=0: dataout = fwd for all ways, purely combinational; read is ignored.
- REG_READ=1:
  - read = 1 in READY: dataout <= fwd at the next edge (1-cycle latency, including same-cycle write data).
  - read = 0: dataout holds its value, even if the held set is later written. The requester must reissue read to see new data.
- Simultaneous read and write to different sets: independent, no interaction.
- Index wrap: none beyond natural S_INDEX width; every index is valid.

Decomposition:
- Package dcache_array_pkg:
  - state enum (CLEAR, READY).
  - lane_merge function (old, new, mask) -> merged entry, shared by the write and forwarding paths.
- Sub-module dcache_way_bank holds one way's storage, the masked write and the forwarding mux.
- The top instantiates WAYS banks via generate and owns the clear FSM, busy and the dataout register.

Test Plan:
Parameters for all scenarios: S_INDEX=3, WIDTH=32, WAYS=2, GRAN=8, REG_READ=1 unless stated.
1. Reset sweep: rst high 1 cycle -> busy high for exactly 8 cycles; then read sets 0..7 -> all dataout words 0x00000000.
2. Masked write: way0 set3 datain 0xAABBCCDD wmask 4'b1111; then datain 0x00001100 wmask 4'b0010; read set3 -> way0 0xAABB11DD, way1 0x00000000.
3. Forwarding: way1 set5 holds 0xFFFFFFFF; same cycle load=2'b10, windex=5, wmask=4'b0011, datain 0x12345678, read=1, rindex=5 -> next cycle way1 0xFFFF5678, way0 unchanged.
4. Hold: read set2 returning 0x0000CAFE; then read=0 and write 0xDEADBEEF to set2 -> dataout stays 0x0000CAFE until the next read, which returns 0xDEADBEEF.
5. Reset mid-sweep: rst again at sweep cycle 4 -> busy stays high 8 more cycles; load during busy to set1 with 0x11111111 -> after sweep set1 reads 0x00000000.
6. REG_READ=0: write way0 set6 0x01020304; in the same cycle rindex=6 -> dataout way0 shows 0x01020304 combinationally in that cycle.
